// File: rtl/dram_cmd_scheduler.sv
// Open-page DRAM command scheduler: turns accesses into PRE/ACT/RD/WR sequences and inserts PREA+REF refreshes.
// Latency: each command is one 4-phase handshake (4 cycles with immediate ack); hit 5, closed 9, miss 13 cycles to rsp_done.
// Backpressure: req_ready is high only while idle with no refresh pending; a stalled cmd_ack holds the whole sequence.
module dram_cmd_scheduler #(
    parameter int NUM_OF_BANKS     = 8,
    parameter int NUM_OF_ROWS      = 128,
    parameter int NUM_OF_COLS      = 8,
    parameter int REFRESH_INTERVAL = 256,
    localparam int BW = $clog2(NUM_OF_BANKS),
    localparam int RW = $clog2(NUM_OF_ROWS),
    localparam int CW = $clog2(NUM_OF_COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_rw,
    input  logic [BW-1:0] req_bank,
    input  logic [RW-1:0] req_row,
    input  logic [CW-1:0] req_col,
    output logic          req_ready,
    output logic          cmd_req,
    input  logic          cmd_ack,
    output logic [2:0]    cmd,
    output logic [BW-1:0] cmd_bank,
    output logic [RW-1:0] cmd_row,
    output logic [CW-1:0] cmd_col,
    output logic          rsp_done,
    output logic          refresh_overrun
);

    localparam int CNTW = $clog2(REFRESH_INTERVAL);

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_ACT  = 3'd1;
    localparam logic [2:0] C_RD   = 3'd2;
    localparam logic [2:0] C_WR   = 3'd3;
    localparam logic [2:0] C_PRE  = 3'd4;
    localparam logic [2:0] C_PREA = 3'd5;
    localparam logic [2:0] C_REF  = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_RW, S_PREA, S_REF, S_DONE} state_t;
    typedef enum logic {PH_REQ, PH_WAIT_LOW} phase_t;

    state_t              r_state;
    phase_t              r_phase;
    logic                r_cmd_req;
    logic [2:0]          r_cmd;
    logic                r_rw;
    logic [BW-1:0]       r_bank;
    logic [RW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic                r_req_ready;
    logic                r_rsp_done;
    logic                r_overrun;
    logic                r_pending;
    logic [CNTW-1:0]     r_ref_cnt;
    logic [NUM_OF_BANKS-1:0] r_open_vld;
    logic [RW-1:0]       r_open_row [NUM_OF_BANKS];

    logic w_ref_hit;
    logic w_cmd_done;
    logic w_xfer;
    logic w_row_hit;

    // Command encoding for the state being entered; the access direction picks RD vs WR.
    function automatic logic [2:0] f_cmd(input state_t s, input logic rw);
        case (s)
            S_PRE:   return C_PRE;
            S_ACT:   return C_ACT;
            S_RW:    return rw ? C_WR : C_RD;
            S_PREA:  return C_PREA;
            S_REF:   return C_REF;
            default: return C_NOP;
        endcase
    endfunction

    assign w_ref_hit  = (r_ref_cnt == CNTW'(REFRESH_INTERVAL - 1));
    // A command finishes when ack has been seen high and is now seen low again.
    assign w_cmd_done = (r_phase == PH_WAIT_LOW) && !cmd_ack &&
                        (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_xfer     = req_valid && r_req_ready;
    assign w_row_hit  = r_open_row[req_bank] == req_row;

    // Free-running refresh timer; pending request and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ref_cnt <= w_ref_hit ? '0 : r_ref_cnt + CNTW'(1);
            if (w_ref_hit) begin
                r_pending <= 1'b1;
                if (r_pending) r_overrun <= 1'b1;
            end else if (w_cmd_done && r_state == S_REF) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Main sequencer: state, handshake phase, open-row table and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= PH_REQ;
            r_cmd_req   <= 1'b0;
            r_cmd       <= C_NOP;
            r_rw        <= 1'b0;
            r_bank      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_done  <= 1'b0;
            r_open_vld  <= '0;
        end else begin
            r_rsp_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        // Refresh wins over any request presented this cycle.
                        r_req_ready <= 1'b0;
                        r_state     <= (|r_open_vld) ? S_PREA : S_REF;
                        r_phase     <= PH_REQ;
                        r_cmd_req   <= 1'b1;
                        r_cmd       <= (|r_open_vld) ? C_PREA : C_REF;
                    end else if (w_xfer) begin
                        r_req_ready <= 1'b0;
                        r_rw        <= req_rw;
                        r_bank      <= req_bank;
                        r_row       <= req_row;
                        r_col       <= req_col;
                        r_phase     <= PH_REQ;
                        r_cmd_req   <= 1'b1;
                        if (!r_open_vld[req_bank]) begin
                            r_state <= S_ACT;
                            r_cmd   <= C_ACT;
                        end else if (w_row_hit) begin
                            r_state <= S_RW;
                            r_cmd   <= f_cmd(S_RW, req_rw);
                        end else begin
                            r_state <= S_PRE;
                            r_cmd   <= C_PRE;
                        end
                    end else begin
                        r_req_ready <= !w_ref_hit;
                    end
                end
                S_DONE: begin
                    r_rsp_done  <= 1'b1;
                    r_state     <= S_IDLE;
                    r_req_ready <= !(r_pending || w_ref_hit);
                end
                default: begin
                    if (r_phase == PH_REQ) begin
                        if (cmd_ack) begin
                            r_cmd_req <= 1'b0;
                            r_cmd     <= C_NOP;
                            r_phase   <= PH_WAIT_LOW;
                        end
                    end else if (!cmd_ack) begin
                        r_phase <= PH_REQ;
                        case (r_state)
                            S_PRE: begin
                                r_open_vld[r_bank] <= 1'b0;
                                r_state   <= S_ACT;
                                r_cmd_req <= 1'b1;
                                r_cmd     <= C_ACT;
                            end
                            S_ACT: begin
                                r_open_vld[r_bank] <= 1'b1;
                                r_open_row[r_bank] <= r_row;
                                r_state   <= S_RW;
                                r_cmd_req <= 1'b1;
                                r_cmd     <= f_cmd(S_RW, r_rw);
                            end
                            S_RW: begin
                                r_state <= S_DONE;
                            end
                            S_PREA: begin
                                r_open_vld <= '0;
                                r_state    <= S_REF;
                                r_cmd_req  <= 1'b1;
                                r_cmd      <= C_REF;
                            end
                            S_REF: begin
                                r_state     <= S_IDLE;
                                r_req_ready <= !w_ref_hit;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign req_ready       = r_req_ready;
    assign cmd_req         = r_cmd_req;
    assign cmd             = r_cmd;
    assign cmd_bank        = r_bank;
    assign cmd_row         = r_row;
    assign cmd_col         = r_col;
    assign rsp_done        = r_rsp_done;
    assign refresh_overrun = r_overrun;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: instance A (refresh 256) covers access sequencing and reset,
// instance B (refresh 16) covers refresh insertion, ack stall and overrun.
// Expected commands are queued when a request is driven and popped as the DUT issues them.
module tb_dram_cmd_scheduler;
    localparam int BW = 3;
    localparam int RW = 7;
    localparam int CW = 3;

    typedef struct packed {
        logic [2:0]    c;
        logic [BW-1:0] b;
        logic [RW-1:0] r;
        logic [CW-1:0] col;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a = 1'b1, rst_b = 1'b1;
    logic          vld_a = 1'b0, vld_b = 1'b0;
    logic          req_rw = 1'b0;
    logic [BW-1:0] req_bank = '0;
    logic [RW-1:0] req_row = '0;
    logic [CW-1:0] req_col = '0;
    logic          ack_a = 1'b0, ack_b = 1'b0;
    logic          rdy_a, creq_a, done_a, ovr_a;
    logic          rdy_b, creq_b, done_b, ovr_b;
    logic [2:0]    cmd_a, cmd_b;
    logic [BW-1:0] cb_a, cb_b;
    logic [RW-1:0] cr_a, cr_b;
    logic [CW-1:0] cc_a, cc_b;
    logic          hold_b = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_a = 0;
    logic pa = 1'b0, pb = 1'b0;
    ent_t qa[$];
    ent_t qb[$];
    int   lqa[$];

    dram_cmd_scheduler #(.REFRESH_INTERVAL(256)) u_dut_a (
        .clk(clk), .rst(rst_a), .req_valid(vld_a), .req_rw(req_rw), .req_bank(req_bank),
        .req_row(req_row), .req_col(req_col), .req_ready(rdy_a), .cmd_req(creq_a),
        .cmd_ack(ack_a), .cmd(cmd_a), .cmd_bank(cb_a), .cmd_row(cr_a), .cmd_col(cc_a),
        .rsp_done(done_a), .refresh_overrun(ovr_a)
    );

    dram_cmd_scheduler #(.REFRESH_INTERVAL(16)) u_dut_b (
        .clk(clk), .rst(rst_b), .req_valid(vld_b), .req_rw(req_rw), .req_bank(req_bank),
        .req_row(req_row), .req_col(req_col), .req_ready(rdy_b), .cmd_req(creq_b),
        .cmd_ack(ack_b), .cmd(cmd_b), .cmd_bank(cb_b), .cmd_row(cr_b), .cmd_col(cc_b),
        .rsp_done(done_b), .refresh_overrun(ovr_b)
    );

    // DRAM models: ack follows cmd_req one cycle later; B can stall RD/WR acks.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ack_a <= creq_a;
        ack_b <= creq_b && !(hold_b && (cmd_b == 3'd2 || cmd_b == 3'd3));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsz(input int s);
        return (s == 0) ? qa.size() : qb.size();
    endfunction

    function automatic ent_t qfront(input int s);
        return (s == 0) ? qa[0] : qb[0];
    endfunction

    function automatic ent_t qpop(input int s);
        if (s == 0) return qa.pop_front();
        return qb.pop_front();
    endfunction

    function automatic void qpush(input int s, input ent_t e);
        if (s == 0) qa.push_back(e);
        else qb.push_back(e);
    endfunction

    // Keep only the fields that matter for the expected command.
    function automatic ent_t mask(input ent_t o, input logic [2:0] ec);
        ent_t m;
        m = o;
        case (ec)
            3'd1:       m.col = '0;
            3'd2, 3'd3: m.r = '0;
            3'd4:       begin m.r = '0; m.col = '0; end
            default:    begin m.b = '0; m.r = '0; m.col = '0; end
        endcase
        return m;
    endfunction

    task automatic observe(input int s, input logic creq, input logic prev, input logic [2:0] c,
                           input logic [BW-1:0] b, input logic [RW-1:0] r,
                           input logic [CW-1:0] col, input logic done);
        ent_t o, e;
        logic skip;
        o = {c, b, r, col};
        if (creq && !prev) begin
            skip = (c == 3'd5 || c == 3'd6) &&
                   (qsz(s) == 0 || (qfront(s).c != 3'd5 && qfront(s).c != 3'd6));
            if (!skip) begin
                if (qsz(s) == 0) chk((s == 0) ? "unexp_cmd_a" : "unexp_cmd_b", 32'(c), 32'd0);
                else begin
                    e = qpop(s);
                    chk((s == 0) ? "cmd_a" : "cmd_b", 32'(mask(o, e.c)), 32'(e));
                end
            end
        end
        if (done) begin
            if (qsz(s) == 0) chk((s == 0) ? "unexp_done_a" : "unexp_done_b", 32'(done), 32'd0);
            else begin
                e = qpop(s);
                chk((s == 0) ? "done_order_a" : "done_order_b", 32'({done, done, done}), 32'(e.c));
            end
            if (s == 0 && lqa.size() > 0) chk("latency_a", 32'(cyc - acc_a), 32'(lqa.pop_front()));
        end
    endtask

    // Monitor: sample away from the active edge, score commands and completions.
    always @(negedge clk) begin
        if (vld_a && rdy_a) acc_a = cyc + 1;
        observe(0, creq_a, pa, cmd_a, cb_a, cr_a, cc_a, done_a);
        observe(1, creq_b, pb, cmd_b, cb_b, cr_b, cc_b, done_b);
        pa = creq_a;
        pb = creq_b;
    end

    // kind: 0 row hit, 1 closed bank, 2 row miss. lat > 0 queues an expected latency (instance A).
    task automatic send(input int s, input logic rw, input logic [BW-1:0] b, input logic [RW-1:0] r,
                        input logic [CW-1:0] c, input int lat, input int kind);
        bit ok;
        if (kind == 2) qpush(s, {3'd4, b, 7'd0, 3'd0});
        if (kind >= 1) qpush(s, {3'd1, b, r, 3'd0});
        qpush(s, {(rw ? 3'd3 : 3'd2), b, 7'd0, c});
        qpush(s, {3'd7, 3'd0, 7'd0, 3'd0});
        if (s == 0 && lat > 0) lqa.push_back(lat);
        @(posedge clk); #1;
        req_rw = rw; req_bank = b; req_row = r; req_col = c;
        if (s == 0) vld_a = 1'b1; else vld_b = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (s == 0) ? rdy_a : rdy_b;
        end
        if (!ok) chk("ready_timeout", 32'((s == 0) ? rdy_a : rdy_b), 32'd1);
        @(posedge clk); #1;
        vld_a = 1'b0; vld_b = 1'b0;
    endtask

    task automatic wait_done(input int s);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (s == 0) ? done_a : done_b;
        end
        if (!ok) chk("done_timeout", 32'((s == 0) ? done_a : done_b), 32'd1);
    endtask

    task automatic wait_cmd(input int s, input logic [2:0] code);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (s == 0) ? (creq_a && cmd_a == code) : (creq_b && cmd_b == code);
        end
        if (!ok) chk("cmd_timeout", 32'((s == 0) ? cmd_a : cmd_b), 32'(code));
    endtask

    initial begin
        int bad;
        bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_req_a", 32'(creq_a), 0);
        chk("rst_cmd_a", 32'(cmd_a), 0);
        chk("rst_fields_a", 32'({cb_a, cr_a, cc_a}), 0);
        chk("rst_ready_a", 32'(rdy_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_ovr_a", 32'(ovr_a), 0);
        chk("rst_cmd_req_b", 32'(creq_b), 0);
        chk("rst_ready_b", 32'(rdy_b), 0);
        @(posedge clk); #1 rst_a = 1'b0;

        // Cold write, then row hit read, then row miss read.
        send(0, 1'b1, 3'd2, 7'd5, 3'd3, 9, 1);
        wait_done(0);
        send(0, 1'b0, 3'd2, 7'd5, 3'd1, 5, 0);
        wait_done(0);
        send(0, 1'b0, 3'd2, 7'd9, 3'd0, 13, 2);
        wait_done(0);

        // Reset while ACT is being requested; the command is abandoned.
        send(0, 1'b1, 3'd6, 7'd3, 3'd1, 0, 1);
        wait_cmd(0, 3'd1);
        @(posedge clk); #1 rst_a = 1'b1;
        @(posedge clk); #1 rst_a = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_req", 32'(creq_a), 0);
        chk("mid_rst_ready", 32'(rdy_a), 0);
        chk("mid_rst_cmd", 32'(cmd_a), 0);
        qa.delete();
        lqa.delete();
        send(0, 1'b0, 3'd2, 7'd5, 3'd7, 9, 1);
        wait_done(0);

        // Refresh with an open bank and a request held against it.
        @(posedge clk); #1 rst_b = 1'b0;
        send(1, 1'b1, 3'd4, 7'd1, 3'd0, 0, 1);
        wait_done(1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = !rdy_b;
        end
        if (!ok) chk("pending_timeout", 32'(rdy_b), 0);
        qb.push_back({3'd5, 3'd0, 7'd0, 3'd0});
        qb.push_back({3'd6, 3'd0, 7'd0, 3'd0});
        @(posedge clk); #1;
        req_rw = 1'b0; req_bank = 3'd4; req_row = 7'd1; req_col = 3'd2;
        vld_b = 1'b1;
        @(negedge clk);
        chk("held_ready_low", 32'(rdy_b), 0);
        send(1, 1'b0, 3'd4, 7'd1, 3'd2, 0, 1);
        wait_done(1);
        chk("ovr_before_stall", 32'(ovr_b), 0);

        // Stall the RD ack for 40 cycles across several refresh intervals.
        hold_b = 1'b1;
        send(1, 1'b0, 3'd1, 7'd7, 3'd4, 0, 1);
        wait_cmd(1, 3'd2);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (!(creq_b && cmd_b == 3'd2 && cb_b == 3'd1 && cc_b == 3'd4)) bad++;
        end
        chk("stall_req_stable", 32'(bad), 0);
        chk("overrun_set", 32'(ovr_b), 1);
        hold_b = 1'b0;
        wait_done(1);
        repeat (20) @(negedge clk);
        chk("overrun_sticky", 32'(ovr_b), 1);

        repeat (5) @(negedge clk);
        chk("queue_a_drained", 32'(qa.size()), 0);
        chk("queue_b_drained", 32'(qb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
